// File: rtl/sirv_aon_keyed_pkg.sv
// ---------------------------------------------------------------------------
// sirv_aon_keyed_pkg : shared encodings for the keyed AON config write path
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sirv_aon_keyed_pkg;

  localparam logic [0:0] ST_LOCKED   = 1'b0;
  localparam logic [0:0] ST_UNLOCKED = 1'b1;

  localparam logic SEL_KEY = 1'b0;
  localparam logic SEL_CFG = 1'b1;

  localparam logic [31:0] DEFAULT_KEY = 32'h0051F15E;

  localparam int unsigned TMR_W = 8;

endpackage

`default_nettype wire

// File: rtl/sirv_aon_unlock_timer.sv
// ---------------------------------------------------------------------------
// sirv_aon_unlock_timer : loadable down-counter that flags unlock expiry
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sirv_aon_unlock_timer
  import sirv_aon_keyed_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic             hold_i,
  input  logic [TMR_W-1:0] load_val_i,
  output logic             expire_o
);

  logic [TMR_W-1:0] tmr_q;
  logic [TMR_W-1:0] tmr_d;

  always_comb begin
    tmr_d = tmr_q;
    if (load_i) begin
      tmr_d = load_val_i;
    end else if (!hold_i && (tmr_q != '0)) begin
      tmr_d = tmr_q - TMR_W'(1);
    end
  end

  // Expiry is the 1->0 step of a free-running decrement only.
  assign expire_o = !load_i && !hold_i && (tmr_q == TMR_W'(1));

  always_ff @(posedge clock) begin
    if (reset) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sirv_aon_keyed_cfg_wr.sv
// ---------------------------------------------------------------------------
// sirv_aon_keyed_cfg_wr : key-protected write front-end for an AON config vector
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sirv_aon_keyed_cfg_wr
  import sirv_aon_keyed_pkg::*;
#(
  parameter int unsigned CFG_W     = 3,
  parameter logic [31:0] KEY       = DEFAULT_KEY,
  parameter int unsigned UNLOCK_TO = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_req_valid,
  output logic             io_req_ready,
  input  logic             io_req_write,
  input  logic             io_req_sel,
  input  logic [31:0]      io_req_wdata,
  output logic             io_resp_valid,
  output logic             io_resp_err,
  output logic [31:0]      io_resp_rdata,
  output logic [CFG_W-1:0] io_cfg_d,
  output logic             io_cfg_en,
  input  logic [CFG_W-1:0] io_cfg_q,
  output logic             io_unlocked
);

  localparam logic [TMR_W-1:0] UNLOCK_LOAD = TMR_W'(UNLOCK_TO);

  logic [0:0]       state_q, state_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_err_q, resp_err_d;
  logic [31:0]      resp_rdata_q, resp_rdata_d;
  logic             cfg_en_q, cfg_en_d;
  logic [CFG_W-1:0] cfg_d_q, cfg_d_d;

  logic             accept;
  logic             wr;
  logic             key_ok;
  logic             unlocked;
  logic             tmr_load;
  logic             tmr_hold;
  logic [TMR_W-1:0] tmr_load_val;
  logic             tmr_expire;

  assign io_req_ready = ~resp_valid_q;
  assign accept       = io_req_valid & io_req_ready;
  assign wr           = accept & io_req_write;
  assign unlocked     = (state_q == ST_UNLOCKED);
  assign key_ok       = wr & (io_req_sel == SEL_KEY) & (io_req_wdata == KEY);

  // Any write while unlocked relocks (or re-keys), so it also restarts the timer.
  assign tmr_load     = key_ok | (wr & unlocked);
  assign tmr_load_val = key_ok ? UNLOCK_LOAD : '0;
  assign tmr_hold     = ~unlocked | wr;

  sirv_aon_unlock_timer u_timer (
    .clock      (clock),
    .reset      (reset),
    .load_i     (tmr_load),
    .hold_i     (tmr_hold),
    .load_val_i (tmr_load_val),
    .expire_o   (tmr_expire)
  );

  always_comb begin
    state_d      = state_q;
    resp_valid_d = accept;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    cfg_en_d     = 1'b0;
    cfg_d_d      = cfg_d_q;

    if (tmr_expire) begin
      state_d = ST_LOCKED;
    end

    if (accept) begin
      if (io_req_write) begin
        if (io_req_sel == SEL_KEY) begin
          if (key_ok) begin
            state_d = ST_UNLOCKED;
          end else begin
            state_d    = ST_LOCKED;
            resp_err_d = 1'b1;
          end
        end else if (unlocked) begin
          cfg_en_d = 1'b1;
          cfg_d_d  = io_req_wdata[CFG_W-1:0];
          state_d  = ST_LOCKED;
        end else begin
          resp_err_d = 1'b1;
        end
      end else if (io_req_sel == SEL_KEY) begin
        resp_rdata_d[0] = unlocked;
      end else begin
        resp_rdata_d[CFG_W-1:0] = io_cfg_q;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_LOCKED;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      cfg_en_q     <= 1'b0;
      cfg_d_q      <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      cfg_en_q     <= cfg_en_d;
      cfg_d_q      <= cfg_d_d;
    end
  end

  assign io_resp_valid = resp_valid_q;
  assign io_resp_err   = resp_err_q;
  assign io_resp_rdata = resp_rdata_q;
  assign io_cfg_en     = cfg_en_q;
  assign io_cfg_d      = cfg_d_q;
  assign io_unlocked   = unlocked;

endmodule

`default_nettype wire

// File: tb/tb_sirv_aon_keyed_cfg_wr.sv
// ---------------------------------------------------------------------------
// tb_sirv_aon_keyed_cfg_wr : scoreboard bench for the keyed config write path
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sirv_aon_keyed_cfg_wr;

  localparam logic [31:0] C_KEY = 32'h0051F15E;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
    logic        en;
    logic [2:0]  d;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic        req_sel = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [2:0]  cfg_d;
  logic        cfg_en;
  logic [2:0]  cfg_q = 3'b101;
  logic        unlocked;

  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  always #5 clock = ~clock;

  // Stand-in for the downstream register vector.
  always @(posedge clock) if (cfg_en) cfg_q <= cfg_d;

  sirv_aon_keyed_cfg_wr u_dut (
    .clock         (clock),
    .reset         (reset),
    .io_req_valid  (req_valid),
    .io_req_ready  (req_ready),
    .io_req_write  (req_write),
    .io_req_sel    (req_sel),
    .io_req_wdata  (req_wdata),
    .io_resp_valid (resp_valid),
    .io_resp_err   (resp_err),
    .io_resp_rdata (resp_rdata),
    .io_cfg_d      (cfg_d),
    .io_cfg_en     (cfg_en),
    .io_cfg_q      (cfg_q),
    .io_unlocked   (unlocked)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Response monitor: pops the scoreboard on every response pulse.
  always @(negedge clock) begin
    if (resp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("cfg_en", {31'b0, cfg_en}, {31'b0, e.en});
        if (e.en) chk("cfg_d", {29'b0, cfg_d}, {29'b0, e.d});
      end
    end else begin
      chk("idle_cfg_en", {31'b0, cfg_en}, 32'd0);
      chk("idle_err", {31'b0, resp_err}, 32'd0);
      chk("idle_rdata", resp_rdata, 32'd0);
    end
  end

  task automatic req(input logic wr, input logic sel, input logic [31:0] wdata,
                     input logic e_err, input logic [31:0] e_rdata,
                     input logic e_en, input logic [2:0] e_d);
    int waited;
    exp_t e;
    waited = 0;
    @(negedge clock);
    while (!req_ready && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    if (!req_ready) chk("ready_timeout", 32'd0, 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_sel   = sel;
    req_wdata = wdata;
    e.err = e_err; e.rdata = e_rdata; e.en = e_en; e.d = e_d;
    sb.push_back(e);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_sel   = 1'b0;
    req_wdata = '0;
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_unlocked", {31'b0, unlocked}, 32'd0);
    chk("rst_cfg_d", {29'b0, cfg_d}, 32'd0);

    // Readback and locked write rejection
    req(1'b0, 1'b1, 32'h0, 1'b0, 32'h5, 1'b0, 3'b0);
    req(1'b1, 1'b1, 32'h6, 1'b1, 32'h0, 1'b0, 3'b0);
    @(negedge clock);
    chk("locked_unlocked", {31'b0, unlocked}, 32'd0);

    // Unlock, status read, commit (upper wdata bits ignored), relock
    req(1'b1, 1'b0, C_KEY, 1'b0, 32'h0, 1'b0, 3'b0);
    @(negedge clock);
    chk("key_unlocked", {31'b0, unlocked}, 32'd1);
    req(1'b0, 1'b0, 32'h0, 1'b0, 32'h1, 1'b0, 3'b0);
    req(1'b1, 1'b1, 32'hA5A5_A5AF, 1'b0, 32'h0, 1'b1, 3'b111);
    @(negedge clock);
    chk("commit_relock", {31'b0, unlocked}, 32'd0);
    req(1'b0, 1'b1, 32'h0, 1'b0, 32'h7, 1'b0, 3'b0);
    req(1'b1, 1'b1, 32'h2, 1'b1, 32'h0, 1'b0, 3'b0);

    // Idle timeout: open for 15 negedges after the key accept, closed on the 16th
    req(1'b1, 1'b0, C_KEY, 1'b0, 32'h0, 1'b0, 3'b0);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clock);
      chk($sformatf("window_k%0d", k), {31'b0, unlocked}, (k <= 15) ? 32'd1 : 32'd0);
    end

    // Write accepted in the expiry cycle still commits
    req(1'b1, 1'b0, C_KEY, 1'b0, 32'h0, 1'b0, 3'b0);
    repeat (14) @(negedge clock);
    req(1'b1, 1'b1, 32'h3, 1'b0, 32'h0, 1'b1, 3'b011);

    // One cycle later the window is closed
    req(1'b1, 1'b0, C_KEY, 1'b0, 32'h0, 1'b0, 3'b0);
    repeat (15) @(negedge clock);
    req(1'b1, 1'b1, 32'h4, 1'b1, 32'h0, 1'b0, 3'b0);

    // Wrong key while unlocked relocks immediately
    req(1'b1, 1'b0, C_KEY, 1'b0, 32'h0, 1'b0, 3'b0);
    req(1'b1, 1'b0, 32'h1234_5678, 1'b1, 32'h0, 1'b0, 3'b0);
    @(negedge clock);
    chk("badkey_unlocked", {31'b0, unlocked}, 32'd0);
    req(1'b1, 1'b1, 32'h5, 1'b1, 32'h0, 1'b0, 3'b0);

    // Reset during a cfg-write acceptance drops the response and pulse
    req(1'b1, 1'b0, C_KEY, 1'b0, 32'h0, 1'b0, 3'b0);
    @(negedge clock);
    reset     = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_sel   = 1'b1;
    req_wdata = 32'h6;
    @(posedge clock);
    #1;
    reset     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_sel   = 1'b0;
    req_wdata = '0;
    @(negedge clock);
    chk("rst_mid_resp", {31'b0, resp_valid}, 32'd0);
    chk("rst_mid_unlocked", {31'b0, unlocked}, 32'd0);
    req(1'b0, 1'b1, 32'h0, 1'b0, 32'h3, 1'b0, 3'b0);
    req(1'b1, 1'b1, 32'h6, 1'b1, 32'h0, 1'b0, 3'b0);

    repeat (3) @(negedge clock);
    chk("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
